recip_nr_pipe: RTL
==================

Name: recip_nr_pipe

Overview:
- Parametrised signed fixed-point reciprocal unit computing out = 1/x.
- Input and output are both Q(W-F).F two's complement.
- Uses Newton-Raphson with a configurable iteration count and seed-LUT size.
- Adds a valid/ready handshake on both sides, a pass-through tag, full signed support, and saturation and divide-by-zero status.
- Sits in the watchdog datapath as the shared divider for rate/period conversions, replacing single-shot start/done reciprocal logic.

Parameters:
- W, 32, total data width in bits (16..48).
- F, 16, fractional bits of input and output (1..W-2).
- ITER, 3, Newton-Raphson iterations (1..6).
- LUT_BITS, 4, mantissa bits indexing the seed LUT (2..6); LUT has 2**LUT_BITS entries.
- TAG_W, 4, width of the pass-through request tag (>=1).

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, request valid.
- in_ready, out, 1, unit can accept a request.
- in_data, in, W, signed operand x, Q(W-F).F.
- in_tag, in, TAG_W, request tag.
- out_valid, out, 1, result valid.
- out_ready, in, 1, consumer accepts result.
- out_data, out, W, signed 1/x, Q(W-F).F.
- out_tag, out, TAG_W, tag of the request that produced this result.
- out_status, out, 2, result status: 00 OK, 01 DIV0, 10 SAT, 11 reserved (never driven).

Behaviour:
Reset and clocking:
- Reset is asynchronous, active-low, on rst_n; clock is clk.
- Reset values: in_ready=1, out_valid=0, out_data=0, out_tag=0, out_status=00, FSM=IDLE.
- Reset mid-operation aborts the operation; no result is produced.

Handshake and occupancy:
- A request is accepted on a clk edge where in_valid && in_ready.
- in_ready=1 only in IDLE, so one operation is in flight at a time.
- in_data and in_tag are captured at acceptance; later input changes are ignored.

FSM states and transitions:
- IDLE → NORM on accept.
- NORM → SEED → (MUL_A → MUL_B) × ITER → DENORM → FIX → OUT.
- OUT → IDLE on out_valid && out_ready.

Latency and output holding:
- Latency is fixed for all inputs, including zero and saturating ones.
- out_valid rises exactly 4+2*ITER cycles after the accepting edge (10 at default).
- out_valid, out_data, out_tag and out_status stay stable while out_ready=0.
- in_ready returns high in the cycle after the output handshake.
- There is no bypass: a new request cannot be accepted in the same cycle as an output handshake.

Per-state datapath:
- NORM: record sign s = x[W-1] and magnitude |x| in W bits. Unsigned magnitude is used, so x = -2^(W-1) is handled. Find the leading-one position p and normalise the mantissa m = |x| scaled into [1,2). Exponent e = p-F.
- SEED: y0 = LUT[mantissa bits directly below the leading one, LUT_BITS wide]. Entry i = round(2^G / (1 + (i+0.5)/2^LUT_BITS)), where G is the internal fraction width.
- MUL_A: t = m*y, truncated to G fraction bits.
- MUL_B: y = y*(2 - t), truncated to G fraction bits.
- DENORM: shift y by -e to give the magnitude in F fraction bits.
- FIX: apply saturation and sign (rules below).

Internal precision:
- G >= W+4 guard bits.
- Full 2G-bit products before truncation.

Accuracy:
- Let ideal = trunc(2^(2F)/|x|).
- For non-saturated, non-zero x: |out_magnitude - ideal| <= 1 LSB.

FIX rules:
- x=0: out_data = 2^(W-1)-1, status DIV0.
- Magnitude > 2^(W-1)-1: clamp magnitude to 2^(W-1)-1, status SAT.
- Sign: out_data = s ? -magnitude : magnitude. The output is therefore never -2^(W-1).
- Otherwise status is OK.

Test Plan:
All scenarios use W=32, F=16, ITER=3, LUT_BITS=4.
- x=0x00020000 (2.0), tag=5 → out_data=0x00008000±1, status 00, out_tag=5, out_valid exactly 10 cycles after accept.
- x=0xFFFC0000 (-4.0) → 0xFFFFC000±1; x=0x80000000 (-32768.0) → 0xFFFFFFFE±1; status 00 for both.
- x=0x00000000 → out_data=0x7FFFFFFF, status 01, latency still 10.
- x=0x00000001 → 0x7FFFFFFF, status 10; x=0xFFFFFFFF → 0x80000001, status 10.
- x=0x00030000 (3.0), tag=9, out_ready held low 5 cycles after out_valid → out_data=0x00005555±1 held stable, in_ready=0 throughout, in_valid pulses ignored; after handshake in_ready=1 next cycle.
- Accept x=0x00010000, assert rst_n low at cycle 4 for 2 cycles, then send x=0x00040000 → no result for first request; second returns 0x00004000±1, outputs at reset values during reset.

Source files
------------

// File: rtl/recip_nr_pipe.sv
// Signed fixed-point reciprocal: normalise, LUT seed, ITER Newton-Raphson steps, denormalise, saturate.
// One operation in flight; fixed latency of 4+2*ITER cycles from accept to out_valid.
module recip_nr_pipe #(
  parameter int W        = 32,
  parameter int F        = 16,
  parameter int ITER     = 3,
  parameter int LUT_BITS = 4,
  parameter int TAG_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       out_status
);

  localparam int G     = W + 4;
  localparam int YW    = G + 2;
  localparam int PW    = 2 * YW;
  localparam int PBW   = $clog2(W);
  localparam int LUT_N = 2 ** LUT_BITS;

  localparam logic [YW-1:0] TWO    = YW'(1) << (G + 1);
  localparam logic [YW-1:0] MAXMAG = (YW'(1) << (W - 1)) - YW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_NORM, S_SEED, S_MUL_A, S_MUL_B, S_DENORM, S_FIX, S_OUT
  } state_t;

  // Seed entry i is 1/(interval midpoint), rounded, in G fraction bits.
  function automatic logic [YW-1:0] seed_calc(input int i);
    logic [63:0] num;
    logic [63:0] den;
    num = 64'd1 << (G + LUT_BITS + 2);
    den = 64'((2 ** (LUT_BITS + 1)) + 2 * i + 1);
    return YW'((num + den) / (64'd2 * den));
  endfunction

  logic [YW-1:0] lut [LUT_N];
  for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
    localparam logic [YW-1:0] SEED = seed_calc(gi);
    assign lut[gi] = SEED;
  end

  state_t             state_q;
  logic [2:0]         iter_q;
  logic [W-1:0]       x_q;
  logic [TAG_W-1:0]   tag_q;
  logic               sign_q;
  logic               zero_q;
  logic [PBW-1:0]     lead_q;
  logic [YW-1:0]      m_q;
  logic [YW-1:0]      y_q;
  logic [YW-1:0]      t_q;
  logic [YW-1:0]      mag_q;
  logic               ovf_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [W-1:0]       out_data_q;
  logic [TAG_W-1:0]   out_tag_q;
  logic [1:0]         out_status_q;

  logic [W-1:0]       absx_d;
  logic [PBW-1:0]     lead_d;
  logic [7:0]         nsh_d;
  logic [YW-1:0]      m_d;
  logic [YW-1:0]      seed_d;
  logic [YW-1:0]      t_d;
  logic [YW-1:0]      y_d;
  int                 sh_d;
  logic               ovf_d;
  logic [YW-1:0]      mag_d;
  logic               sat_d;
  logic [W-1:0]       fmag_d;
  logic [W-1:0]       fdata_d;
  logic [1:0]         status_d;

  always_comb begin
    // Unsigned magnitude keeps -2^(W-1) representable.
    absx_d = x_q[W-1] ? (~x_q + W'(1)) : x_q;
    lead_d = '0;
    for (int i = 0; i < W; i++) begin
      if (absx_d[i]) lead_d = PBW'(i);
    end
    nsh_d  = 8'(G - int'(lead_d));
    m_d    = YW'(absx_d) << nsh_d;

    seed_d = lut[m_q[G-1 -: LUT_BITS]];
    t_d    = YW'((PW'(m_q) * PW'(y_q)) >> G);
    y_d    = YW'((PW'(y_q) * PW'(TWO - t_q)) >> G);

    // Negative shift means a left shift of y >= 0.5, which always overflows W-1 bits.
    sh_d   = G + int'(lead_q) - 2 * F;
    ovf_d  = (sh_d < 0);
    mag_d  = ovf_d ? '0 : (y_q >> 8'(sh_d));

    sat_d    = ovf_q || (mag_q > MAXMAG);
    fmag_d   = (zero_q || sat_d) ? W'(MAXMAG) : W'(mag_q);
    fdata_d  = (sign_q && !zero_q) ? (~fmag_d + W'(1)) : fmag_d;
    status_d = zero_q ? 2'b01 : (sat_d ? 2'b10 : 2'b00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      iter_q       <= '0;
      x_q          <= '0;
      tag_q        <= '0;
      sign_q       <= 1'b0;
      zero_q       <= 1'b0;
      lead_q       <= '0;
      m_q          <= '0;
      y_q          <= '0;
      t_q          <= '0;
      mag_q        <= '0;
      ovf_q        <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_tag_q    <= '0;
      out_status_q <= 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            x_q        <= in_data;
            tag_q      <= in_tag;
            in_ready_q <= 1'b0;
            state_q    <= S_NORM;
          end
        end
        S_NORM: begin
          sign_q  <= x_q[W-1];
          zero_q  <= (absx_d == '0);
          lead_q  <= lead_d;
          m_q     <= m_d;
          state_q <= S_SEED;
        end
        S_SEED: begin
          y_q     <= seed_d;
          iter_q  <= '0;
          state_q <= S_MUL_A;
        end
        S_MUL_A: begin
          t_q     <= t_d;
          state_q <= S_MUL_B;
        end
        S_MUL_B: begin
          y_q <= y_d;
          if (iter_q == 3'(ITER - 1)) begin
            state_q <= S_DENORM;
          end else begin
            iter_q  <= iter_q + 3'd1;
            state_q <= S_MUL_A;
          end
        end
        S_DENORM: begin
          mag_q   <= mag_d;
          ovf_q   <= ovf_d;
          state_q <= S_FIX;
        end
        S_FIX: begin
          out_data_q   <= fdata_d;
          out_tag_q    <= tag_q;
          out_status_q <= status_d;
          out_valid_q  <= 1'b1;
          state_q      <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_tag    = out_tag_q;
  assign out_status = out_status_q;

endmodule
